// File: rtl/dma_bus_arb_pkg.sv
// Shared types and defaults for the CPU/DMA slave-bus arbiter.
package dma_bus_arb_pkg;

    typedef enum logic {
        CPU_s = 1'b0,
        DMA_s = 1'b1
    } state_t;

    localparam int unsigned CPU_SLOTS_DEF = 2;
    localparam int unsigned HOLD_MAX_DEF  = 1024;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

endpackage

// File: rtl/dma_bus_arb.sv
// Two-master (CPU, DMA) single-slave arbiter with post-release CPU slot
// guarantee and a sticky DMA lock watchdog.
module dma_bus_arb
    import dma_bus_arb_pkg::*;
#(
    parameter int unsigned CPU_SLOTS = CPU_SLOTS_DEF,
    parameter int unsigned HOLD_MAX  = HOLD_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wd,
    input  logic [SIZE_W-1:0] cpu_size,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_stall,
    input  logic              bus_req,
    input  logic              bus_lock,
    output logic              bus_grant,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic              we_m,
    input  logic [DATA_W-1:0] wd_m,
    input  logic [SIZE_W-1:0] size_m,
    output logic [DATA_W-1:0] rd_m,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_we,
    output logic [DATA_W-1:0] s_wd,
    output logic [SIZE_W-1:0] s_size,
    input  logic [DATA_W-1:0] s_rd,
    input  logic              err_clr,
    output logic              lock_err
);

    localparam int unsigned SLOT_W = (CPU_SLOTS > 0) ? $clog2(CPU_SLOTS + 1) : 1;
    localparam int unsigned HOLD_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LOAD = SLOT_W'(CPU_SLOTS);
    localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    state_t            state;
    logic [SLOT_W-1:0] slot_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              wd_hit;

    always_comb begin
        wd_hit = (HOLD_MAX != 0) && (state == DMA_s) && (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CPU_s;
            bus_grant <= 1'b0;
            slot_cnt  <= '0;
            hold_cnt  <= '0;
            lock_err  <= 1'b0;
        end else begin
            // A watchdog hit in the same cycle as err_clr keeps the error set.
            if (wd_hit)
                lock_err <= 1'b1;
            else if (err_clr)
                lock_err <= 1'b0;

            case (state)
                CPU_s: begin
                    if (slot_cnt != '0)
                        slot_cnt <= slot_cnt - SLOT_W'(1);
                    if (bus_req && (slot_cnt == '0)) begin
                        state     <= DMA_s;
                        bus_grant <= 1'b1;
                    end
                end
                DMA_s: begin
                    if (hold_cnt != HOLD_TOP)
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    // Ownership is defined by the lock alone; bus_req is ignored here.
                    if (!bus_lock) begin
                        state     <= CPU_s;
                        bus_grant <= 1'b0;
                        slot_cnt  <= SLOT_LOAD;
                        hold_cnt  <= '0;
                    end
                end
                default: state <= CPU_s;
            endcase
        end
    end

    always_comb begin
        s_addr    = cpu_addr;
        s_we      = cpu_we & cpu_req;
        s_wd      = cpu_wd;
        s_size    = cpu_size;
        cpu_stall = 1'b0;
        if (state == DMA_s) begin
            s_addr    = addr_m;
            s_we      = we_m;
            s_wd      = wd_m;
            s_size    = size_m;
            cpu_stall = cpu_req;
        end
    end

    assign cpu_rd = s_rd;
    assign rd_m   = s_rd;

endmodule

// File: tb/tb_dma_bus_arb.sv
// Directed-vector bench for dma_bus_arb with a queue-based scoreboard.
module tb_dma_bus_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_wd = '0;
    logic [1:0]  cpu_size = 2'd1;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    logic        bus_req = 1'b0;
    logic        bus_lock = 1'b0;
    logic        bus_grant;
    logic [31:0] addr_m = '0;
    logic        we_m = 1'b0;
    logic [31:0] wd_m = '0;
    logic [1:0]  size_m = 2'd2;
    logic [31:0] rd_m;
    logic [31:0] s_addr;
    logic        s_we;
    logic [31:0] s_wd;
    logic [1:0]  s_size;
    logic [31:0] s_rd = '0;
    logic        err_clr = 1'b0;
    logic        lock_err;

    dma_bus_arb #(.CPU_SLOTS(2), .HOLD_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wd(cpu_wd),
        .cpu_size(cpu_size), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .bus_req(bus_req), .bus_lock(bus_lock), .bus_grant(bus_grant),
        .addr_m(addr_m), .we_m(we_m), .wd_m(wd_m), .size_m(size_m), .rd_m(rd_m),
        .s_addr(s_addr), .s_we(s_we), .s_wd(s_wd), .s_size(s_size), .s_rd(s_rd),
        .err_clr(err_clr), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        g;
        logic        st;
        logic        le;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  sz;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 1'b0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, act, req);
        end
    endtask

    // Expected outputs for a cycle whose owner is stated by hand (dma), taken from current drives.
    task automatic expect_cycle(input string nm, input logic dma, input logic le);
        exp_t e;
        e.nm = nm;
        e.g  = dma;
        e.le = le;
        e.rd = s_rd;
        if (dma) begin
            e.st = cpu_req; e.addr = addr_m; e.we = we_m; e.wd = wd_m; e.sz = size_m;
        end else begin
            e.st = 1'b0; e.addr = cpu_addr; e.we = cpu_we & cpu_req; e.wd = cpu_wd; e.sz = cpu_size;
        end
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "bus_grant", {31'd0, bus_grant}, {31'd0, e.g});
                chk(e.nm, "cpu_stall", {31'd0, cpu_stall}, {31'd0, e.st});
                chk(e.nm, "lock_err",  {31'd0, lock_err},  {31'd0, e.le});
                chk(e.nm, "s_addr",    s_addr, e.addr);
                chk(e.nm, "s_we",      {31'd0, s_we}, {31'd0, e.we});
                chk(e.nm, "s_wd",      s_wd, e.wd);
                chk(e.nm, "s_size",    {30'd0, s_size}, {30'd0, e.sz});
                chk(e.nm, "cpu_rd",    cpu_rd, e.rd);
                chk(e.nm, "rd_m",      rd_m, e.rd);
            end
        end
    end

    initial begin : stimulus
        // Reset held with bus_req high: no grant, CPU on the bus.
        rst = 1'b1; bus_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wd = 32'h11;
        step(); expect_cycle("rst_hold", 1'b0, 1'b0);
        step(); rst = 1'b0; expect_cycle("rst_drop", 1'b0, 1'b0);
        step(); bus_lock = 1'b1; cpu_req = 1'b0; addr_m = 32'h2000; we_m = 1'b0; wd_m = 32'hD0;
        expect_cycle("first_grant", 1'b1, 1'b0);

        step(); rst = 1'b1; bus_req = 1'b0; bus_lock = 1'b0; expect_cycle("rst2", 1'b0, 1'b0);

        // CPU write in the request-sample cycle completes; then DMA owns the bus.
        step(); rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wd = 32'hA5;
        bus_req = 1'b1; bus_lock = 1'b1; addr_m = 32'h2000; we_m = 1'b1; wd_m = 32'hD0;
        expect_cycle("cpu_wr_at_req", 1'b0, 1'b0);
        step(); bus_req = 1'b0; we_m = 1'b0; s_rd = 32'hCAFE0000;
        expect_cycle("dma0_stall", 1'b1, 1'b0);
        step(); cpu_req = 1'b0; addr_m = 32'h3000; we_m = 1'b1; wd_m = 32'h1;
        expect_cycle("dma1_wr", 1'b1, 1'b0);
        step(); addr_m = 32'h2000; we_m = 1'b0; s_rd = 32'h12345678;
        expect_cycle("dma2_rd", 1'b1, 1'b0);
        step(); addr_m = 32'h3000; we_m = 1'b1; wd_m = 32'h2;
        expect_cycle("dma3_wr", 1'b1, 1'b0);

        // Release with immediate re-request: release cycle, 2 slot cycles, sample cycle.
        step(); bus_lock = 1'b0; bus_req = 1'b1; addr_m = 32'h2000; we_m = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
        expect_cycle("release_cycle", 1'b1, 1'b0);
        step(); cpu_addr = 32'h204; expect_cycle("slot1", 1'b0, 1'b0);
        step(); cpu_addr = 32'h208; expect_cycle("slot2", 1'b0, 1'b0);
        step(); cpu_addr = 32'h20C; expect_cycle("slot_sample", 1'b0, 1'b0);

        // Lock held 20 DMA cycles; watchdog fires after the 8th.
        for (int i = 1; i <= 20; i++) begin
            step(); bus_lock = 1'b1; bus_req = 1'b0; cpu_req = 1'b0;
            addr_m = 32'h4000 + 32'(i * 4); we_m = 1'b0;
            expect_cycle($sformatf("hold%0d", i), 1'b1, (i >= 9));
        end
        step(); bus_lock = 1'b0; expect_cycle("wd_release", 1'b1, 1'b1);
        step(); expect_cycle("wd_sticky", 1'b0, 1'b1);
        step(); err_clr = 1'b1; expect_cycle("clr_pulse", 1'b0, 1'b1);
        step(); err_clr = 1'b0; expect_cycle("clr_done", 1'b0, 1'b0);

        // Lock without request in CPU_s does not grant.
        step(); bus_lock = 1'b1; expect_cycle("lock_only0", 1'b0, 1'b0);
        step(); expect_cycle("lock_only1", 1'b0, 1'b0);

        // Async reset mid-transfer.
        step(); bus_req = 1'b1; expect_cycle("req_again", 1'b0, 1'b0);
        step(); addr_m = 32'h5000; cpu_addr = 32'h300; cpu_req = 1'b1;
        expect_cycle("dma_before_rst", 1'b1, 1'b0);
        step(); rst = 1'b1; expect_cycle("async_rst", 1'b0, 1'b0);
        step(); rst = 1'b0; bus_req = 1'b0; expect_cycle("post_rst_idle", 1'b0, 1'b0);
        step(); bus_req = 1'b1; expect_cycle("post_rst_req", 1'b0, 1'b0);
        step(); expect_cycle("post_rst_grant", 1'b1, 1'b0);

        step(); step();
        done = 1'b1;
    end

    initial begin : finisher
        int unsigned budget;
        budget = 0;
        while (!done && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (!done || q.size() != 0) begin
            errors++;
            $display("FAIL completion: done=%0d pending=%0d required done=1 pending=0", done, q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
